branch_resolve_ctrl: RTL and testbench

//  Sequences branch resolution for the 16-bit pipeline. It takes the branch in EX, evaluates its
//  Rs condition (EQZ/NEZ/LTZ/GEZ) and compares the outcome with the fetch-time prediction.
//  On a mismatch it issues a one-cycle PC redirect and a multi-cycle pipeline flush.
//  It also stalls EX while Rs is unresolved and owns the 2-bit branch history table that feeds fetch.

---
 rtl/branch_resolve_ctrl_pkg.sv | 23 ++
 rtl/branch_resolve_ctrl_bht_2bit.sv | 46 ++++
 rtl/branch_resolve_ctrl.sv | 155 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for the branch resolution controller: branch condition
// codes, controller states and the branch-history counter reset value.
package branch_resolve_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_BEQZ = 2'b00,
    BR_BNEZ = 2'b01,
    BR_BLTZ = 2'b10,
    BR_BGEZ = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT_RS = 2'b01,
    S_FLUSH   = 2'b10
  } state_e;

  // Weakly not-taken: one taken outcome flips the prediction to taken.
  localparam logic [1:0] BHT_INIT = 2'b01;

  localparam int PC_W = 16;

endpackage

// File: rtl/branch_resolve_ctrl_bht_2bit.sv
// Table of 2-bit saturating branch-history counters. One combinational read
// port for fetch and one synchronous update port for the resolving branch.
// A same-entry read and write in one cycle returns the pre-update value.
module bht_2bit
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [ENTRIES];

  // Move a counter one step toward the observed outcome, clamped to 0..3.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && (ctr != 2'b11)) begin
      res = ctr + 2'b01;
    end else if (!taken && (ctr != 2'b00)) begin
      res = ctr - 2'b01;
    end
    return res;
  endfunction

  // Counter storage: reinitialise every entry on reset, else apply one update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_INIT;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= sat_step(ctr_q[upd_idx], upd_taken);
    end
  end

  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the 16-bit pipeline. Evaluates the EX
// branch condition on Rs, checks it against the fetch-time prediction, issues
// a one-cycle redirect plus a multi-cycle flush on mispredict, stalls EX while
// Rs is outstanding, and trains the branch-history table read by fetch.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_taken,
  input  logic            br_valid,
  input  logic [1:0]      br_type,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_rs,
  input  logic            br_rs_ready,
  input  logic            br_pred_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] br_pc_plus2,
  output logic            stall,
  output logic            resolve_valid,
  output logic            resolved_taken,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [15:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  // The redirect cycle is the first flush cycle, so the counter starts one short.
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e          state_q;
  state_e          state_d;
  logic [FC_W-1:0] flush_cnt_q;
  logic            resolve;
  logic            taken;
  logic            mispredict;
  logic [1:0]      rd_ctr;
  logic            unused_pc_bits;

  // Branch condition on Rs: zero test and sign bit.
  function automatic logic cond_taken(input logic [1:0] kind, input logic signed [PC_W-1:0] rs);
    logic res;
    case (br_type_e'(kind))
      BR_BEQZ: res = (rs == '0);
      BR_BNEZ: res = (rs != '0);
      BR_BLTZ: res = rs[PC_W-1];
      BR_BGEZ: res = !rs[PC_W-1];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Mispredict count clamps at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign resolve    = br_valid && br_rs_ready && (state_q != S_FLUSH);
  assign taken      = cond_taken(br_type, br_rs);
  assign mispredict = resolve && (taken != br_pred_taken);
  assign flush      = (state_q == S_FLUSH);
  assign pred_taken = rd_ctr[1];

  // Only the halfword index bits of each PC address the table.
  assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_W+1], fetch_pc[0],
                            br_pc[PC_W-1:IDX_W+1], br_pc[0]};

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (fetch_pc[IDX_W:1]),
    .rd_ctr    (rd_ctr),
    .upd_en    (resolve),
    .upd_idx   (br_pc[IDX_W:1]),
    .upd_taken (taken)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and zero-latency stall.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (resolve) begin
          state_d = mispredict ? S_FLUSH : S_IDLE;
        end else if (br_valid) begin
          stall   = 1'b1;
          state_d = S_WAIT_RS;
        end
      end
      S_WAIT_RS: begin
        stall = !br_rs_ready;
        if (resolve) begin
          state_d = mispredict ? S_FLUSH : S_IDLE;
        end else if (!br_valid) begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Remaining flush cycles after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else if (mispredict) begin
      flush_cnt_q <= FLUSH_LOAD;
    end else if ((state_q == S_FLUSH) && (flush_cnt_q != '0)) begin
      flush_cnt_q <= flush_cnt_q - 1'b1;
    end
  end

  // Registered resolve/redirect pulses and the mispredict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      resolve_valid  <= 1'b0;
      resolved_taken <= 1'b0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
      mispred_cnt    <= '0;
    end else begin
      resolve_valid  <= resolve;
      resolved_taken <= resolve && taken;
      redirect       <= mispredict;
      redirect_pc    <= mispredict ? (taken ? br_target : br_pc_plus2) : '0;
      if (mispredict) begin
        mispred_cnt <= sat_inc(mispred_cnt);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a cycle-level reference model
// and hand-computed anchor values.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [15:0] br_pc;
  logic [15:0] br_rs;
  logic        br_rs_ready;
  logic        br_pred_taken;
  logic [15:0] br_target;
  logic [15:0] br_pc_plus2;
  logic        stall;
  logic        resolve_valid;
  logic        resolved_taken;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush;
  logic [15:0] mispred_cnt;

  localparam int FLUSH_CYCLES = 2;

  branch_resolve_ctrl #(
    .BHT_ENTRIES  (16),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .br_valid       (br_valid),
    .br_type        (br_type),
    .br_pc          (br_pc),
    .br_rs          (br_rs),
    .br_rs_ready    (br_rs_ready),
    .br_pred_taken  (br_pred_taken),
    .br_target      (br_target),
    .br_pc_plus2    (br_pc_plus2),
    .stall          (stall),
    .resolve_valid  (resolve_valid),
    .resolved_taken (resolved_taken),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          m_bht [16];
  int          m_flush_left;
  bit          m_wait;
  bit          e_rv, e_rt, e_redir;
  logic [15:0] e_rpc;
  logic [15:0] e_cnt;
  bit          model_on = 0;

  function automatic bit model_taken(input logic [1:0] t, input logic [15:0] rs);
    case (t)
      2'd0:    return rs == 16'd0;
      2'd1:    return rs != 16'd0;
      2'd2:    return $signed(rs) < 0;
      default: return $signed(rs) >= 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_flush_left = 0;
      m_wait = 0;
      e_rv = 0; e_rt = 0; e_redir = 0; e_rpc = 0; e_cnt = 0;
    end else begin
      bit tk;
      int ix;
      e_rv = 0; e_rt = 0; e_redir = 0; e_rpc = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
        m_wait = 0;
      end else if (br_valid && br_rs_ready) begin
        tk = model_taken(br_type, br_rs);
        ix = int'(br_pc[4:1]);
        e_rv = 1;
        e_rt = tk;
        if (tk) m_bht[ix] = (m_bht[ix] < 3) ? m_bht[ix] + 1 : 3;
        else    m_bht[ix] = (m_bht[ix] > 0) ? m_bht[ix] - 1 : 0;
        if (tk != br_pred_taken) begin
          e_redir = 1;
          e_rpc = tk ? br_target : br_pc_plus2;
          if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
          m_flush_left = FLUSH_CYCLES;
        end
        m_wait = 0;
      end else begin
        m_wait = br_valid;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("stall", stall, 32'((m_flush_left == 0) && !br_rs_ready && (m_wait || br_valid)));
      check("pred_taken", pred_taken, 32'(m_bht[int'(fetch_pc[4:1])] >= 2));
      check("resolve_valid", resolve_valid, 32'(e_rv));
      check("resolved_taken", resolved_taken, 32'(e_rt));
      check("redirect", redirect, 32'(e_redir));
      check("redirect_pc", redirect_pc, 32'(e_rpc));
      check("flush", flush, 32'(m_flush_left > 0));
      check("mispred_cnt", mispred_cnt, 32'(e_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [1:0] t, input logic [15:0] pc, input logic [15:0] rs,
                        input logic rdy, input logic pred, input logic [15:0] tgt);
    br_valid = 1'b1; br_type = t; br_pc = pc; br_rs = rs; br_rs_ready = rdy;
    br_pred_taken = pred; br_target = tgt; br_pc_plus2 = pc + 16'd2;
  endtask

  task automatic clr_br();
    br_valid = 1'b0; br_rs_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, st, rv;
    rst = 1'b1; fetch_pc = '0; br_valid = 0; br_type = '0; br_pc = '0; br_rs = '0;
    br_rs_ready = 0; br_pred_taken = 0; br_target = '0; br_pc_plus2 = '0;
    tick();
    model_on = 1;
    tick();
    @(negedge clk);
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect, 0);
    check("rst_mispred_cnt", mispred_cnt, 0);
    rst = 1'b0;
    tick();

    // 1: all entries weakly not-taken after reset
    for (int i = 0; i < 16; i++) begin
      fetch_pc = 16'(i * 2);
      @(negedge clk);
      check("t1_pred_init", pred_taken, 0);
      tick();
    end
    // 1b: reset during FLUSH drops everything
    set_br(2'd0, 16'h0030, 16'h0000, 1, 0, 16'h0050);
    tick();
    clr_br();
    @(negedge clk);
    check("t1_redirect_before_rst", redirect, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t1_flush_after_rst", flush, 0);
    check("t1_redirect_after_rst", redirect, 0);
    tick();

    // 2: BEQZ taken, predicted not-taken
    fetch_pc = 16'h0010;
    set_br(2'd0, 16'h0010, 16'h0000, 1, 0, 16'h0040);
    tick();
    clr_br();
    fl = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("t2_redirect", redirect, 1);
        check("t2_redirect_pc", redirect_pc, 16'h0040);
        check("t2_mispred_cnt", mispred_cnt, 1);
        check("t2_bht8_taken", pred_taken, 1);
      end
      fl += int'(flush);
      tick();
    end
    check("t2_flush_len", fl, 2);

    // 3: BLTZ correctly predicted taken, three back-to-back
    fetch_pc = 16'h0006;
    repeat (3) begin
      set_br(2'd2, 16'h0006, 16'h8000, 1, 1, 16'h0100);
      tick();
    end
    clr_br();
    @(negedge clk);
    check("t3_resolve_valid", resolve_valid, 1);
    check("t3_resolved_taken", resolved_taken, 1);
    check("t3_no_redirect", redirect, 0);
    check("t3_no_flush", flush, 0);
    tick();
    set_br(2'd2, 16'h0006, 16'h0001, 1, 1, 16'h0100);
    tick();
    clr_br();
    @(negedge clk);
    check("t3_sat_pred", pred_taken, 1);
    check("t3_fallthrough_pc", redirect_pc, 16'h0008);
    repeat (3) tick();

    // 4: BGEZ with Rs late by 3 cycles
    set_br(2'd3, 16'h0012, 16'h7FFF, 0, 0, 16'h0200);
    st = 0;
    repeat (3) begin
      @(negedge clk);
      st += int'(stall);
      tick();
    end
    br_rs_ready = 1'b1;
    @(negedge clk);
    st += int'(stall);
    tick();
    clr_br();
    @(negedge clk);
    check("t4_stall_cycles", st, 3);
    check("t4_redirect", redirect, 1);
    check("t4_redirect_pc", redirect_pc, 16'h0200);
    repeat (3) tick();

    // 5: BNEZ mispredict, second branch during FLUSH is ignored
    fetch_pc = 16'h000A;
    set_br(2'd1, 16'h0008, 16'h0005, 1, 0, 16'h0300);
    tick();
    set_br(2'd0, 16'h000A, 16'h0000, 1, 0, 16'h0400);
    @(negedge clk);
    check("t5_first_resolve", resolve_valid, 1);
    rv = 0;
    tick();
    @(negedge clk);
    rv += int'(resolve_valid);
    tick();
    clr_br();
    @(negedge clk);
    rv += int'(resolve_valid);
    check("t5_ignored_resolves", rv, 0);
    check("t5_bht5_unchanged", pred_taken, 0);
    check("t5_redirect_clear", redirect, 0);
    repeat (2) tick();

    // 6: mispredict counter saturation
    force dut.mispred_cnt = 16'hFFFE;
    e_cnt = 16'hFFFE;
    #1;
    release dut.mispred_cnt;
    @(negedge clk);
    check("t6_preload", mispred_cnt, 16'hFFFE);
    tick();
    repeat (2) begin
      set_br(2'd0, 16'h0014, 16'h0000, 1, 0, 16'h0500);
      tick();
      clr_br();
      @(negedge clk);
      check("t6_cnt_sat", mispred_cnt, 16'hFFFF);
      repeat (3) tick();
    end

    model_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
